mem_interface: RTL and testbench

- MAR/MDR register pair plus SRAM access sequencer for the LC-3 datapath.
- Sits directly downstream of the DataBus mux: loads MAR/MDR from DataBus and drives MDR back as the DataMDR bus source.
- Runs fixed-length read/write cycles to the external SRAM under a req/ready handshake from the control FSM.

---
 rtl/mem_interface.sv | 156 +++++++++++++++
 tb/tb_mem_interface.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_interface: LC-3 MAR/MDR register pair and fixed-length SRAM sequencer   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_interface #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] DataBus,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        MIO_EN,
    input  logic        Mem_Req,
    input  logic        Mem_WE,
    output logic        Mem_Ready,
    output logic        Busy,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;

    generate
        if (WAIT_CYCLES < 2) begin : g_wait_cycles_check
            $error("mem_interface: WAIT_CYCLES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        mar_q, mar_d;
    logic [15:0]        mdr_q, mdr_d;
    logic [15:0]        rdata_q, rdata_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;

        mar_d = LD_MAR ? DataBus : mar_q;
        mdr_d = LD_MDR ? (MIO_EN ? rdata_q : DataBus) : mdr_q;

        unique case (state_q)
            ST_IDLE: begin
                // Latch the pre-edge MAR/MDR so a same-cycle load targets the next access.
                if (Mem_Req) begin
                    addr_d   = mar_q;
                    dq_out_d = mdr_q;
                    cnt_d    = CNT_W'(WAIT_CYCLES - 1);
                    state_d  = Mem_WE ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (cnt_q == '0) begin
                    rdata_d = SRAM_DQ_in;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they appear registered, glitch-free.
        ready_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
        ce_n_d  = !((state_d == ST_READ) || (state_d == ST_WRITE));
        oe_n_d  = (state_d != ST_READ);
        dq_oe_d = (state_d == ST_WRITE);
        // WE_N releases in the last write cycle to give the SRAM data hold time.
        we_n_d  = !((state_d == ST_WRITE) && (cnt_d != '0));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
        end
    end

    assign Mem_Ready   = ready_q;
    assign Busy        = busy_q;
    assign MAR         = mar_q;
    assign MDR         = mdr_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ_out = dq_out_q;
    assign SRAM_DQ_oe  = dq_oe_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_interface.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_interface: two instances (WAIT_CYCLES 2 and 4) against access rules  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_interface;

    typedef struct packed {
        logic        rdy;
        logic        busy;
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic        dq_oe;
        logic [15:0] mar;
        logic [15:0] mdr;
        logic [15:0] addr;
        logic [15:0] dqo;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus;
    logic        ld_mar, ld_mdr, mio_en, mem_we;
    logic [1:0]  req;
    logic [15:0] dq_in;

    logic [1:0]  rdy_o, busy_o, dq_oe_o, ce_n_o, oe_n_o, we_n_o;
    logic [15:0] mar_o  [2];
    logic [15:0] mdr_o  [2];
    logic [15:0] addr_o [2];
    logic [15:0] dqo_o  [2];

    logic [15:0] exp_rdata [2];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_interface #(.WAIT_CYCLES(2)) u_dut2 (
        .Clk(clk), .Reset_n(rst_n), .DataBus(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
        .MIO_EN(mio_en), .Mem_Req(req[0]), .Mem_WE(mem_we), .Mem_Ready(rdy_o[0]),
        .Busy(busy_o[0]), .MAR(mar_o[0]), .MDR(mdr_o[0]), .SRAM_ADDR(addr_o[0]),
        .SRAM_DQ_out(dqo_o[0]), .SRAM_DQ_in(dq_in), .SRAM_DQ_oe(dq_oe_o[0]),
        .SRAM_CE_N(ce_n_o[0]), .SRAM_OE_N(oe_n_o[0]), .SRAM_WE_N(we_n_o[0])
    );

    mem_interface #(.WAIT_CYCLES(4)) u_dut4 (
        .Clk(clk), .Reset_n(rst_n), .DataBus(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
        .MIO_EN(mio_en), .Mem_Req(req[1]), .Mem_WE(mem_we), .Mem_Ready(rdy_o[1]),
        .Busy(busy_o[1]), .MAR(mar_o[1]), .MDR(mdr_o[1]), .SRAM_ADDR(addr_o[1]),
        .SRAM_DQ_out(dqo_o[1]), .SRAM_DQ_in(dq_in), .SRAM_DQ_oe(dq_oe_o[1]),
        .SRAM_CE_N(ce_n_o[1]), .SRAM_OE_N(oe_n_o[1]), .SRAM_WE_N(we_n_o[1])
    );

    function automatic obs_t sample(input int i);
        sample = {rdy_o[i], busy_o[i], ce_n_o[i], oe_n_o[i], we_n_o[i], dq_oe_o[i],
                  mar_o[i], mdr_o[i], addr_o[i], dqo_o[i]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; mem_we = 1'b0; req = 2'b00;
    endtask

    task automatic test_reset();
        obs_t exp, got;
        idle_inputs();
        bus = 16'hFFFF; dq_in = 16'hAAAA; rst_n = 1'b0;
        step(); step();
        exp = '0; exp.ce_n = 1'b1; exp.oe_n = 1'b1; exp.we_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            got = sample(i);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset dut%0d got=%h exp=%h", i, got, exp);
            end
        end
        #2 rst_n = 1'b1;
        exp_rdata[0] = 16'h0; exp_rdata[1] = 16'h0;
        step();
    endtask

    // Loads MAR/MDR, runs one access, then pulls rdata into MDR during DONE.
    task automatic do_access(input int w, input bit we, input logic [15:0] a,
                             input logic [15:0] d, input logic [15:0] rd, input bit poke);
        int i;
        obs_t exp, got;
        i = (w == 4) ? 1 : 0;
        bus = a; ld_mar = 1'b1; step();
        bus = d; ld_mar = 1'b0; ld_mdr = 1'b1; mio_en = 1'b0; step();
        ld_mdr = 1'b0;
        dq_in = rd; mem_we = we; req[i] = 1'b1; bus = 16'($urandom);
        step();
        req[i] = 1'b0;
        for (int k = 1; k <= w + 1; k++) begin
            exp = {(k == w + 1), 1'b1, !(k <= w), !(!we && k <= w), !(we && k < w),
                   (we && k <= w), a, d, a, d};
            got = sample(i);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL access w=%0d we=%0d cycle=%0d got=%h exp=%h", w, we, k, got, exp);
            end
            req[i] = poke && (k <= w);
            ld_mdr = (k == w + 1);
            mio_en = (k == w + 1);
            step();
        end
        ld_mdr = 1'b0; mio_en = 1'b0; req = 2'b00;
        if (!we) exp_rdata[i] = rd;
        exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, a, exp_rdata[i], a, d};
        for (int k = 0; k < 2; k++) begin
            got = sample(i);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL after_access w=%0d we=%0d idle%0d got=%h exp=%h", w, we, k, got, exp);
            end
            step();
        end
    endtask

    task automatic test_read();
        do_access(2, 1'b0, 16'h3001, 16'($urandom), 16'hBEEF, 1'b0);
    endtask

    task automatic test_write();
        do_access(2, 1'b1, 16'h0042, 16'h1234, 16'hDEAD, 1'b0);
    endtask

    task automatic test_req_ignored_while_busy();
        do_access(2, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
        do_access(4, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    endtask

    task automatic test_same_cycle_ld_mar();
        logic [15:0] r;
        r = 16'($urandom);
        bus = 16'h0010; ld_mar = 1'b1; step();
        bus = 16'h7777; req[0] = 1'b1; mem_we = 1'b0; dq_in = r; step();
        ld_mar = 1'b0; req = 2'b00;
        n_cmp++;
        if (addr_o[0] !== 16'h0010) begin
            n_bad++;
            $display("FAIL same_cycle_addr got=%h exp=%h", addr_o[0], 16'h0010);
        end
        n_cmp++;
        if (mar_o[0] !== 16'h7777) begin
            n_bad++;
            $display("FAIL same_cycle_mar got=%h exp=%h", mar_o[0], 16'h7777);
        end
        step(); step(); step();
        exp_rdata[0] = r;
        n_cmp++;
        if (busy_o[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL same_cycle_idle busy got=%b exp=0", busy_o[0]);
        end
    endtask

    // Continuous request on the 4-cycle instance: period is 4 READ + DONE + IDLE.
    task automatic test_back_to_back();
        logic [2:0] exp, got;
        int ph;
        dq_in = 16'($urandom); mem_we = 1'b0; req[1] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            ph = c % 6;
            exp = {(ph == 5), !(ph >= 1 && ph <= 4), (ph != 0)};
            got = {rdy_o[1], oe_n_o[1], busy_o[1]};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL back_to_back cycle=%0d rdy/oe_n/busy got=%b exp=%b", c, got, exp);
            end
        end
        req = 2'b00;
        exp_rdata[1] = dq_in;
        step();
    endtask

    task automatic test_reset_mid_write();
        obs_t exp, got;
        bus = 16'h0042; ld_mar = 1'b1; step();
        bus = 16'h1234; ld_mar = 1'b0; ld_mdr = 1'b1; mio_en = 1'b0; step();
        ld_mdr = 1'b0; req[0] = 1'b1; mem_we = 1'b1; step();
        req = 2'b00;
        n_cmp++;
        if (we_n_o[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_write_we_n got=%b exp=0", we_n_o[0]);
        end
        rst_n = 1'b0;
        #1;
        exp = '0; exp.ce_n = 1'b1; exp.oe_n = 1'b1; exp.we_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            got = sample(i);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_mid_write dut%0d got=%h exp=%h", i, got, exp);
            end
        end
        #2 rst_n = 1'b1;
        exp_rdata[0] = 16'h0; exp_rdata[1] = 16'h0;
        step();
        do_access(2, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 16; n++) begin
            w = ($urandom_range(0, 1) == 0) ? 2 : 4;
            do_access(w, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                      16'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_same_cycle_ld_mar();
        test_req_ignored_while_busy();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
